// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_display
// Brief    : Captures a packed BCD word and time-multiplexes its digits onto a
//            common-segment 7-segment display, updating only at frame edges.
// Revision : 1.0  initial release
// ============================================================================
module bcd_scan_display #(
  parameter int NUM_DIGITS    = 3,
  parameter int REFRESH_DIV   = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    bad_digit
);

  localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

  logic [c_CNT_W-1:0]      cnt_q, cnt_d;
  logic [c_IDX_W-1:0]      idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    wrap_q, wrap_d;

  logic                    w_tick;
  logic                    w_boundary;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [3:0]              w_sel_nib;
  logic                    w_sel_blank;
  logic [6:0]              w_seg_d;
  logic [NUM_DIGITS-1:0]   w_an_d;
  logic                    w_bad_d;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Scan timing and the pending/displayed word handoff.
  always_comb begin
    w_tick     = (cnt_q == c_CNT_LAST);
    w_boundary = w_tick && (idx_q == c_IDX_LAST);
    wrap_d     = w_boundary;

    cnt_d = w_tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (w_tick) begin
      idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (load) begin
      if (w_boundary) begin
        disp_d       = bcd_in;
        pend_valid_d = 1'b0;
      end else begin
        pend_d       = bcd_in;
        pend_valid_d = 1'b1;
      end
    end else if (w_boundary && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end
  end

  // w_lz[k] is set when digits k..NUM_DIGITS-1 are all zero; invalid nibbles are nonzero.
  always_comb begin
    logic acc;
    acc  = 1'b1;
    w_lz = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc     = acc && (disp_q[4*k +: 4] == 4'd0);
      w_lz[k] = acc;
    end
  end

  always_comb begin
    w_sel_nib   = 4'd0;
    w_sel_blank = 1'b0;
    w_an_d      = '0;
    w_bad_d     = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_an_d[k] = (idx_q == c_IDX_W'(k));
      if (idx_q == c_IDX_W'(k)) begin
        w_sel_nib   = disp_q[4*k +: 4];
        w_sel_blank = BLANK_LEADING && (k > 0) && w_lz[k];
      end
      if (disp_q[4*k +: 4] > 4'd9) begin
        w_bad_d = 1'b1;
      end
    end
    w_seg_d = w_sel_blank ? 7'h00 : f_decode(w_sel_nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      seg          <= 7'h00;
      an           <= '0;
      frame_tick   <= 1'b0;
      bad_digit    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      wrap_q       <= wrap_d;
      seg          <= w_seg_d;
      an           <= w_an_d;
      // Delayed one extra cycle so the pulse lines up with digit 0 reaching an/seg.
      frame_tick   <= wrap_q;
      bad_digit    <= w_bad_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_display
// Brief    : Self-checking bench for bcd_scan_display (three configurations).
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_scan_display;

  localparam int c_N = 3;

  logic        clk;
  logic        rst;
  logic        load;
  logic [11:0] bcd_in;

  logic [2:0][6:0] d_seg;
  logic [2:0][2:0] d_an;
  logic [2:0]      d_ft;
  logic [2:0]      d_bad;

  // Config 0: R=4 blank, config 1: R=4 no blank, config 2: R=1 blank.
  bcd_scan_display #(.NUM_DIGITS(3), .REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .seg(d_seg[0]), .an(d_an[0]), .frame_tick(d_ft[0]), .bad_digit(d_bad[0]));
  bcd_scan_display #(.NUM_DIGITS(3), .REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .seg(d_seg[1]), .an(d_an[1]), .frame_tick(d_ft[1]), .bad_digit(d_bad[1]));
  bcd_scan_display #(.NUM_DIGITS(3), .REFRESH_DIV(1), .BLANK_LEADING(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .seg(d_seg[2]), .an(d_an[2]), .frame_tick(d_ft[2]), .bad_digit(d_bad[2]));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got=%0h expected=%0h", name, i, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int          m_rdiv  [3] = '{4, 4, 1};
  bit          m_blank [3] = '{1'b1, 1'b0, 1'b1};
  logic [11:0] m_disp  [3];
  logic [11:0] m_pend  [3];
  bit          m_pv    [3];
  int          m_cyc   [3];
  logic [6:0]  e_seg   [3];
  logic [2:0]  e_an    [3];
  logic        e_ft    [3];
  logic        e_bad   [3];

  function automatic logic [6:0] m_glyph(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] m_seg_of(input logic [11:0] w, input int k, input bit blank);
    int upper;
    upper = int'(w) >> (4 * k);
    if (blank && k > 0 && upper == 0) return 7'h00;
    return m_glyph(upper % 16);
  endfunction

  initial begin : model
    int  c, frame, idx;
    bit  bnd;
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          m_disp[i] = '0; m_pend[i] = '0; m_pv[i] = 1'b0; m_cyc[i] = 0;
          e_seg[i] = '0; e_an[i] = '0; e_ft[i] = 1'b0; e_bad[i] = 1'b0;
        end else begin
          c     = m_cyc[i];
          frame = m_rdiv[i] * c_N;
          idx   = (c / m_rdiv[i]) % c_N;
          e_an[i]  = 3'b001 << idx;
          e_seg[i] = m_seg_of(m_disp[i], idx, m_blank[i]);
          e_ft[i]  = (c > 0) && (c % frame == 0);
          e_bad[i] = 1'b0;
          for (int k = 0; k < c_N; k++)
            if (((int'(m_disp[i]) >> (4 * k)) % 16) > 9) e_bad[i] = 1'b1;
          bnd = (c % frame == frame - 1);
          if (load) begin
            if (bnd) begin m_disp[i] = bcd_in; m_pv[i] = 1'b0; end
            else begin m_pend[i] = bcd_in; m_pv[i] = 1'b1; end
          end else if (bnd && m_pv[i]) begin
            m_disp[i] = m_pend[i]; m_pv[i] = 1'b0;
          end
          m_cyc[i] = c + 1;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          chk("model_seg", i, d_seg[i], e_seg[i]);
          chk("model_an",  i, d_an[i],  e_an[i]);
          chk("model_ft",  i, d_ft[i],  e_ft[i]);
          chk("model_bad", i, d_bad[i], e_bad[i]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [6:0] g_seg [2][3];
  logic       g_bad;

  task automatic wait_ft();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (d_ft[0]) begin seen = 1'b1; break; end
    end
    if (!seen) chk("ft_timeout", 0, 0, 1);
  endtask

  task automatic load_word(input logic [11:0] v);
    bcd_in = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Called on a frame_tick cycle: records one digit per slot for configs 0 and 1.
  task automatic grab();
    g_bad = d_bad[0];
    for (int d = 0; d < 3; d++) begin
      g_seg[0][d] = d_seg[0];
      g_seg[1][d] = d_seg[1];
      if (d < 2) repeat (4) @(negedge clk);
    end
  endtask

  task automatic expect3(input string name, input int dut, input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
    chk({name, "_u"}, dut, g_seg[dut][0], u);
    chk({name, "_t"}, dut, g_seg[dut][1], t);
    chk({name, "_h"}, dut, g_seg[dut][2], h);
  endtask

  task automatic show(input logic [11:0] v);
    wait_ft();
    load_word(v);
    wait_ft();
    grab();
  endtask

  task automatic post_reset_checks(input string name);
    int gap;
    logic [2:0] ea;
    @(negedge clk);
    chk({name, "_an0"},  0, d_an[0],  3'b001);
    chk({name, "_seg0"}, 0, d_seg[0], 7'h3F);
    chk({name, "_ft0"},  0, d_ft[0],  1'b0);
    chk({name, "_an2"},  2, d_an[2],  3'b001);
    gap = 0;
    // Digit 0 reappears with frame_tick one full frame (12 clocks) later.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        ea = 3'b001 << (k % 3);
        chk({name, "_fast_an"}, k, d_an[2], ea);
      end
      if (k == 3) chk({name, "_fast_ft"}, k, d_ft[2], 1'b1);
      if (d_ft[0]) begin gap = k; break; end
    end
    chk({name, "_ft_gap"}, 0, gap, 12);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [6:0] pat [3];
    logic [2:0] ea;
    logic [11:0] w;
    rst = 1'b0; load = 1'b0; bcd_in = '0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_seg", i, d_seg[i], 7'h00);
      chk("rst_an",  i, d_an[i],  3'b000);
    end
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    post_reset_checks("boot");

    // Scan pattern for 255.
    wait_ft();
    load_word(12'h255);
    wait_ft();
    pat[0] = 7'h6D; pat[1] = 7'h6D; pat[2] = 7'h5B;
    for (int j = 0; j < 12; j++) begin
      ea = 3'b001 << (j / 4);
      chk("t1_an",  j, d_an[0],  ea);
      chk("t1_seg", j, d_seg[0], pat[j / 4]);
      chk("t1_ft",  j, d_ft[0],  (j == 0));
      chk("t1_bad", j, d_bad[0], 1'b0);
      @(negedge clk);
    end
    chk("t1_wrap_an", 0, d_an[0], 3'b001);
    chk("t1_wrap_ft", 0, d_ft[0], 1'b1);

    // Blanking and decode.
    show(12'h007);
    expect3("t2_007", 0, 7'h07, 7'h00, 7'h00);
    expect3("t2_007", 1, 7'h07, 7'h3F, 7'h3F);
    show(12'h000);
    expect3("t2_000", 0, 7'h3F, 7'h00, 7'h00);
    show(12'h100);
    expect3("t2_100", 0, 7'h3F, 7'h3F, 7'h06);
    show(12'h0A3);
    expect3("t3_0A3", 0, 7'h4F, 7'h40, 7'h00);
    chk("t3_bad", 0, g_bad, 1'b1);
    show(12'h255);
    chk("t3_bad_clear", 0, g_bad, 1'b0);

    // Frame sync: mid-frame load must not disturb the current frame.
    wait_ft();
    repeat (4) @(negedge clk);
    chk("t4_tens_an",  0, d_an[0],  3'b010);
    chk("t4_tens_seg", 0, d_seg[0], 7'h6D);
    load_word(12'h123);
    repeat (3) @(negedge clk);
    chk("t4_hund_seg", 0, d_seg[0], 7'h5B);
    wait_ft();
    grab();
    expect3("t4_123", 0, 7'h4F, 7'h5B, 7'h06);
    wait_ft();
    load_word(12'h111);
    repeat (3) @(negedge clk);
    load_word(12'h999);
    wait_ft();
    grab();
    expect3("t4_999", 0, 7'h6F, 7'h6F, 7'h6F);

    // Load landing exactly on the boundary cycle.
    wait_ft();
    repeat (10) @(negedge clk);
    load_word(12'h456);
    wait_ft();
    grab();
    expect3("t5_456", 0, 7'h7D, 7'h6D, 7'h66);
    wait_ft();
    grab();
    expect3("t5_hold", 0, 7'h7D, 7'h6D, 7'h66);

    // Asynchronous reset in the middle of the tens slot.
    wait_ft();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_seg", i, d_seg[i], 7'h00);
      chk("t6_an",  i, d_an[i],  3'b000);
      chk("t6_ft",  i, d_ft[i],  1'b0);
      chk("t6_bad", i, d_bad[i], 1'b0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    post_reset_checks("t6");

    // Randomised traffic, checked against the model every cycle.
    for (int n = 0; n < 600; n++) begin
      w = '0;
      for (int k = 0; k < 3; k++)
        w[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bcd_in = w;
      load   = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    repeat (30) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Downstream consumer of the binary-to-BCD converter output. It captures a packed BCD word and time-multiplexes its digits onto a common-segment 7-segment display, one digit per refresh slot. Display data changes only at frame boundaries, so no frame shows a mix of old and new digits. Optionally blanks leading zeros and flags non-decimal nibbles.

Parameters:
NUM_DIGITS, 3, number of BCD digits/display positions (>=1); digit 0 = units
REFRESH_DIV, 1000, clk cycles per digit slot (>=1)
BLANK_LEADING, 1, 1 = blank leading zero digits, 0 = show all digits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
load  in  1  one-cycle strobe; capture bcd_in
bcd_in  in  4*NUM_DIGITS  packed BCD, digit k at [4k+3:4k]
seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered
an  out  NUM_DIGITS  one-hot digit enable, active-high, registered
frame_tick  out  1  one-cycle pulse when digit 0 of a new frame is driven
bad_digit  out  1  registered; 1 while the displayed word holds any nibble >9

Behaviour:
- Reset is asynchronous and active-high. It clears prescaler, idx, disp, pend, pend_valid, seg, an, frame_tick and bad_digit to 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick = (count == REFRESH_DIV-1). With REFRESH_DIV=1, tick is asserted every cycle.
- Digit index idx: 0..NUM_DIGITS-1. On tick, idx advances by 1, and wraps to 0 from NUM_DIGITS-1 (frame boundary).
- Load path:
  - load=1 writes bcd_in to pend and sets pend_valid.
  - A second load before the boundary overwrites pend; the last value wins.
  - load is never dropped. There is no backpressure.
- Frame boundary (tick with idx==NUM_DIGITS-1):
  - If pend_valid, then disp<=pend and pend_valid<=0.
  - If load coincides with the boundary, bcd_in goes straight to disp and pend_valid ends 0.
- Output register (1-cycle latency from idx/disp):
  - an <= one-hot(idx).
  - seg <= decode(digit idx of disp).
  - bad_digit <= OR over digits (nibble>9).
  - frame_tick <= 1 in the cycle after the edge where idx wrapped to 0; otherwise 0.
  - First clock after reset release: an = 1 (digit 0), seg = decode of disp digit 0 (0x3F).
- Decode table:
  - Digits 0–9: 0 0x3F, 1 0x06, 2 0x5B, 3 0x4F, 4 0x66, 5 0x6D, 6 0x7D, 7 0x07, 8 0x7F, 9 0x6F.
  - Nibble >9: dash 0x40.
  - Blank: 0x00.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit k>0 is blanked when digits k..NUM_DIGITS-1 of disp are all 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - Invalid nibbles count as nonzero.
- Mid-operation reset clears state immediately; the scan restarts from digit 0 and the display shows 0.
- Widths: all index and counter widths use $clog2 with a minimum of 1 bit. No arithmetic overflow paths exist.

Test Plan:
NUM_DIGITS=3, REFRESH_DIV=4 unless stated.
1. Reset, load 12'h255, wait for frame_tick → then an=001 seg=0x6D for 4 cycles, an=010 seg=0x6D, an=100 seg=0x5B, wrap with frame_tick=1 on the an=001 cycle; bad_digit=0.
2. Load 12'h007 → units 0x07, tens 0x00, hundreds 0x00. Repeat with BLANK_LEADING=0 → tens/hundreds 0x3F. Load 12'h000 → units 0x3F, others 0x00. Load 12'h100 → 0x3F, 0x3F, 0x06 (inner zero not blanked).
3. Load 12'h0A3 → units 0x4F, tens 0x40, hundreds 0x00 not blanked? No: hundreds 0 but A counts nonzero, so hundreds blanked only above A → hundreds 0x00, tens 0x40; bad_digit=1 from the following frame until a valid word is displayed.
4. Frame sync: while showing 12'h255, load 12'h123 during the tens slot → tens/hundreds still show 5/2 in this frame; next frame 0x4F, 0x5B, 0x06. Load 12'h111 then 12'h999 in the same frame → only 999 appears.
5. Load asserted exactly on the boundary cycle (idx=2, count=3) with 12'h456 → next frame shows 6,5,4 and pend_valid=0 afterwards; no repeat update at the following boundary.
6. Assert rst asynchronously mid-slot (idx=1, count=2) → seg=0, an=0, frame_tick=0, bad_digit=0 immediately. After release: an=001 seg=0x3F, and the first frame_tick occurs after 12 cycles. Repeat with REFRESH_DIV=1 → an rotates every cycle.
